// File: rtl/video_pkg.sv
// Shared constants for the video resync controller: FSM states, mode codes, counter widths.
package video_pkg;

    localparam int unsigned HCNT_W = 13;
    localparam int unsigned VCNT_W = 10;

    localparam logic [HCNT_W-1:0] HCNT_MAX = {HCNT_W{1'b1}};
    localparam logic [VCNT_W-1:0] VCNT_MAX = {VCNT_W{1'b1}};

    typedef logic [1:0] ctrlState;

    localparam ctrlState StSearch = 2'd0;
    localparam ctrlState StVerify = 2'd1;
    localparam ctrlState StResync = 2'd2;
    localparam ctrlState StLocked = 2'd3;

    localparam logic [1:0] MODE_NTSC  = 2'd0;
    localparam logic [1:0] MODE_PAL   = 2'd1;
    localparam logic [1:0] MODE_OTHER = 2'd2;

    function automatic logic [1:0] classifyMode(input logic [VCNT_W-1:0] lines,
                                                input logic [VCNT_W-1:0] palLines,
                                                input logic [VCNT_W-1:0] ntscLines);
        if (lines == palLines) begin
            return MODE_PAL;
        end else if (lines == ntscLines) begin
            return MODE_NTSC;
        end
        return MODE_OTHER;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an asynchronous level, with registered rise/fall pulses.
module sync_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [1:0] syncQ;
    logic       prevQ;
    logic       riseQ;
    logic       fallQ;

    always_ff @(posedge clk) begin
        if (reset) begin
            syncQ <= 2'b00;
            prevQ <= 1'b0;
            riseQ <= 1'b0;
            fallQ <= 1'b0;
        end else begin
            syncQ <= {syncQ[0], din};
            prevQ <= syncQ[1];
            riseQ <= syncQ[1] & ~prevQ;
            fallQ <= ~syncQ[1] & prevQ;
        end
    end

    assign rise = riseQ;
    assign fall = fallQ;

endmodule

// File: rtl/video_resync_ctrl.sv
// Measures C64 line/frame timing, waits for it to settle, then fires one HDMI resync pulse
// at the start of active video and supervises the resulting lock.
module video_resync_ctrl
    import video_pkg::*;
#(
    parameter int unsigned STABLE_FRAMES = 4,
    parameter int unsigned H_TOL         = 2,
    parameter int unsigned PAL_LINES     = 312,
    parameter int unsigned NTSC_LINES    = 263
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hs,
    input  logic        vs,
    input  logic        de,
    input  logic        ntscmode,
    output logic [1:0]  mode,
    output logic        locked,
    output logic        vreset,
    output logic [12:0] line_len,
    output logic [9:0]  frame_lines
);

    localparam int unsigned STABLE_W = $clog2(STABLE_FRAMES + 1);
    localparam logic [STABLE_W-1:0] STABLE_TARGET = STABLE_W'(STABLE_FRAMES);
    localparam logic [HCNT_W-1:0]   HTOL          = HCNT_W'(H_TOL);
    localparam logic [VCNT_W-1:0]   PAL_L         = VCNT_W'(PAL_LINES);
    localparam logic [VCNT_W-1:0]   NTSC_L        = VCNT_W'(NTSC_LINES);

    logic hsFall, vsFall, deRise;
    logic hsRise, vsRise, deFall;
    logic unusedEdges;

    sync_edge_det uHsSync (.clk(clk), .reset(reset), .din(hs), .rise(hsRise), .fall(hsFall));
    sync_edge_det uVsSync (.clk(clk), .reset(reset), .din(vs), .rise(vsRise), .fall(vsFall));
    sync_edge_det uDeSync (.clk(clk), .reset(reset), .din(de), .rise(deRise), .fall(deFall));

    assign unusedEdges = hsRise ^ vsRise ^ deFall;

    logic [HCNT_W-1:0]   hcnt, hcntD;
    logic [VCNT_W-1:0]   vcnt, vcntD, vcntInc;
    logic [HCNT_W-1:0]   lineLenQ, lineLenD, refLenQ, lenDiff;
    logic [VCNT_W-1:0]   frameLinesQ, frameLinesD, refLinesQ;
    logic [STABLE_W-1:0] stableCntQ, stableCntD;
    ctrlState            stateQ, stateD;
    logic                vresetQ, vresetD;
    logic [1:0]          modeQ;
    logic                watchdog, frameMatch, capture;

    // Measurements fold in this cycle's events so the FSM judges the frame that just closed.
    always_comb begin
        lineLenD = lineLenQ;
        hcntD    = (hcnt == HCNT_MAX) ? hcnt : hcnt + 1'b1;
        if (hsFall) begin
            lineLenD = (hcnt == HCNT_MAX) ? HCNT_MAX : hcnt + 1'b1;
            hcntD    = '0;
        end
        vcntInc     = (hsFall && vcnt != VCNT_MAX) ? vcnt + 1'b1 : vcnt;
        frameLinesD = vsFall ? vcntInc : frameLinesQ;
        vcntD       = vsFall ? '0 : vcntInc;
    end

    assign lenDiff    = (lineLenD >= refLenQ) ? lineLenD - refLenQ : refLenQ - lineLenD;
    assign frameMatch = (lenDiff <= HTOL) && (frameLinesD == refLinesQ);
    assign watchdog   = (hcnt == HCNT_MAX) || (vcnt == VCNT_MAX);

    always_comb begin
        stateD     = stateQ;
        stableCntD = stableCntQ;
        capture    = 1'b0;
        vresetD    = 1'b0;
        if (watchdog) begin
            stateD = StSearch;
        end else begin
            case (stateQ)
                StSearch: begin
                    if (vsFall) begin
                        capture    = 1'b1;
                        stableCntD = '0;
                        stateD     = StVerify;
                    end
                end
                StVerify: begin
                    if (vsFall && frameMatch) begin
                        stableCntD = stableCntQ + 1'b1;
                        if (stableCntQ + 1'b1 == STABLE_TARGET) begin
                            stateD = StResync;
                        end
                    end else if (vsFall) begin
                        capture    = 1'b1;
                        stableCntD = '0;
                    end
                end
                StResync: begin
                    // Reaching another vs without seeing de means the frame is not as expected.
                    if (vsFall) begin
                        capture    = 1'b1;
                        stableCntD = '0;
                        stateD     = StVerify;
                    end else if (deRise) begin
                        vresetD = 1'b1;
                        stateD  = StLocked;
                    end
                end
                StLocked: begin
                    if (vsFall && !frameMatch) begin
                        capture    = 1'b1;
                        stableCntD = '0;
                        stateD     = StVerify;
                    end
                end
                default: stateD = StSearch;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt        <= '0;
            vcnt        <= '0;
            lineLenQ    <= '0;
            frameLinesQ <= '0;
            refLenQ     <= '0;
            refLinesQ   <= '0;
            stableCntQ  <= '0;
            stateQ      <= StSearch;
            vresetQ     <= 1'b0;
            modeQ       <= MODE_NTSC;
        end else begin
            hcnt        <= hcntD;
            vcnt        <= vcntD;
            lineLenQ    <= lineLenD;
            frameLinesQ <= frameLinesD;
            stableCntQ  <= stableCntD;
            stateQ      <= stateD;
            vresetQ     <= vresetD;
            if (capture) begin
                refLenQ   <= lineLenD;
                refLinesQ <= frameLinesD;
            end
            modeQ <= (stateQ == StLocked) ? classifyMode(frameLinesQ, PAL_L, NTSC_L)
                                          : {1'b0, ~ntscmode};
        end
    end

    assign locked      = (stateQ == StLocked);
    assign vreset      = vresetQ;
    assign mode        = modeQ;
    assign line_len    = lineLenQ;
    assign frame_lines = frameLinesQ;

endmodule
